game_tick_scheduler: RTL

Central timebase and tick scheduler for the Pong game. Divides the 50 MHz board clock to a 10 kHz base rate and issues single-cycle enable strobes: display scan, paddle update and ball update. A run/serve/pause state machine gates these strobes. Ball speed scales with rally length. All downstream game logic runs on clk, qualified by these strobes.

---
 rtl/game_tick_scheduler.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/game_tick_scheduler.sv
// Pong timebase: divides clk to a base tick and issues scan/paddle/ball strobes gated by an IDLE/SERVE/RUN/PAUSED FSM.
// Optional macro TICK_DEBUG_EN adds debug_step for single-stepping the game strobes while PAUSED.
module game_tick_scheduler #(
  parameter int unsigned CLK_DIV        = 5000,
  parameter int unsigned PADDLE_DIV     = 100,
  parameter int unsigned BALL_DIV_INIT  = 200,
  parameter int unsigned BALL_DIV_STEP  = 20,
  parameter int unsigned BALL_DIV_MIN   = 40,
  parameter int unsigned HITS_PER_LEVEL = 4,
  parameter int unsigned SERVE_TICKS    = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause_req,
  input  logic       paddle_hit,
  input  logic       point_scored,
  input  logic       game_over,
`ifdef TICK_DEBUG_EN
  input  logic       debug_step,
`endif
  output logic       scan_tick,
  output logic       paddle_tick,
  output logic       ball_tick,
  output logic [3:0] speed_level,
  output logic [1:0] state
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);
  localparam int unsigned PW = $clog2(PADDLE_DIV + 1);
  localparam int unsigned BW = $clog2(BALL_DIV_INIT + 1);
  localparam int unsigned SW = $clog2(SERVE_TICKS + 1);
  localparam int unsigned HW = $clog2(HITS_PER_LEVEL + 1);

  typedef enum logic [1:0] {IDLE = 2'b00, SERVE = 2'b01, RUN = 2'b10, PAUSED = 2'b11} st_e;

  st_e           st;
  logic [CW-1:0] base_cnt;
  logic [PW-1:0] pad_cnt;
  logic [BW-1:0] ball_cnt;
  logic [SW-1:0] serve_cnt;
  logic [HW-1:0] hits;
  logic          base_tick;
  logic          dbg;
  logic [31:0]   red;
  logic [31:0]   ball_div;

  assign state     = st;
  assign base_tick = (base_cnt == CW'(CLK_DIV - 1));

`ifdef TICK_DEBUG_EN
  assign dbg = debug_step && (st == PAUSED);
`else
  assign dbg = 1'b0;
`endif

  // Floor test done before subtracting so the divider never wraps below zero.
  always_comb begin
    red      = 32'(speed_level) * BALL_DIV_STEP;
    ball_div = (red + BALL_DIV_MIN >= BALL_DIV_INIT) ? BALL_DIV_MIN : BALL_DIV_INIT - red;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st          <= IDLE;
      base_cnt    <= '0;
      pad_cnt     <= '0;
      ball_cnt    <= '0;
      serve_cnt   <= '0;
      hits        <= '0;
      speed_level <= '0;
      scan_tick   <= 1'b0;
      paddle_tick <= 1'b0;
      ball_tick   <= 1'b0;
    end else begin
      base_cnt    <= base_tick ? '0 : base_cnt + CW'(1);
      scan_tick   <= base_tick;
      paddle_tick <= dbg;
      ball_tick   <= dbg;

      if (base_tick && (st == SERVE || st == RUN)) begin
        if (pad_cnt == PW'(PADDLE_DIV - 1)) begin
          pad_cnt     <= '0;
          paddle_tick <= 1'b1;
        end else begin
          pad_cnt <= pad_cnt + PW'(1);
        end
      end

      // >= lets a divider that shrank mid-count fire on the next base tick.
      if (base_tick && st == RUN) begin
        if (32'(ball_cnt) + 32'd1 >= ball_div) begin
          ball_cnt  <= '0;
          ball_tick <= 1'b1;
        end else begin
          ball_cnt <= ball_cnt + BW'(1);
        end
      end

      if (game_over) begin
        st          <= IDLE;
        speed_level <= '0;
        hits        <= '0;
        pad_cnt     <= '0;
        ball_cnt    <= '0;
        serve_cnt   <= '0;
      end else begin
        case (st)
          IDLE: if (start) begin
            st        <= SERVE;
            serve_cnt <= '0;
            ball_cnt  <= '0;
          end
          SERVE: if (base_tick) begin
            if (serve_cnt == SW'(SERVE_TICKS - 1)) begin
              st        <= RUN;
              serve_cnt <= '0;
            end else begin
              serve_cnt <= serve_cnt + SW'(1);
            end
          end
          RUN: begin
            if (point_scored) begin
              st          <= SERVE;
              speed_level <= '0;
              hits        <= '0;
              ball_cnt    <= '0;
              serve_cnt   <= '0;
            end else if (pause_req) begin
              st <= PAUSED;
            end else if (paddle_hit) begin
              if (hits == HW'(HITS_PER_LEVEL - 1)) begin
                hits <= '0;
                if (speed_level != 4'd15) speed_level <= speed_level + 4'd1;
              end else begin
                hits <= hits + HW'(1);
              end
            end
          end
          PAUSED: if (pause_req) st <= RUN;
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule
